load_unit: RTL and testbench

Multi-cycle memory load unit for the CPU datapath, sitting between the memory-data stage and the register-file write-back mux. It accepts a load command (byte address plus size code), issues a word-aligned read request to data memory with a ready handshake, and extracts the addressed byte, half, word or doubleword lane. It then sign- or zero-extends the result to DATA_W, flags misaligned accesses and memory timeouts, and holds the result until the next completion.

---
 rtl/load_pkg.sv | 44 ++++
 rtl/load_unit_if.sv | 18 +
 rtl/load_unit_extract.sv | 39 +++
 rtl/load_unit.sv | 127 ++++++++++++
 tb/tb_load_unit.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/load_pkg.sv
// load_pkg: shared definitions for the load unit.
//   - size-code constants for the load_size field
//   - FSM state type
//   - helpers: byte-offset width from the datapath width, command fault check
package load_pkg;

  localparam logic [2:0] LS_LW  = 3'b000;
  localparam logic [2:0] LS_LB  = 3'b001;
  localparam logic [2:0] LS_LH  = 3'b010;
  localparam logic [2:0] LS_LBU = 3'b011;
  localparam logic [2:0] LS_LHU = 3'b100;
  localparam logic [2:0] LS_LWU = 3'b101;
  localparam logic [2:0] LS_LD  = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of address bits that select a byte inside one memory word.
  function automatic int off_width(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // True when the command cannot be served: misaligned lane, reserved
  // code, or a 64-bit-only code on a 32-bit datapath. off is the byte
  // offset zero-extended to 3 bits.
  function automatic logic is_fault(input logic [2:0] size,
                                    input logic [2:0] off,
                                    input int         data_w);
    logic f;
    case (size)
      LS_LB, LS_LBU: f = 1'b0;
      LS_LH, LS_LHU: f = off[0];
      LS_LW:         f = (off[1:0] != 2'b00);
      LS_LWU:        f = (data_w == 32) || (off[1:0] != 2'b00);
      LS_LD:         f = (data_w == 32) || (off != 3'b000);
      default:       f = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/load_unit_if.sv
// load_unit_if: data-memory read port of the load unit.
//   mem_rd_req  read request (held until accepted or abandoned)
//   mem_addr    word-aligned byte address
//   mem_rdata   read data, meaningful only while mem_ready=1
//   mem_ready   memory accept-and-data-valid
// master = load unit side, slave = memory side.
interface load_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              mem_rd_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (output mem_rd_req, mem_addr, input mem_rdata, mem_ready);
  modport slave  (input mem_rd_req, mem_addr, output mem_rdata, mem_ready);
endinterface

// File: rtl/load_unit_extract.sv
// load_extract: combinational lane select and sign/zero extension.
//   word    memory word (little-endian byte lanes)
//   off     byte offset of the lane inside the word
//   size    load size code (load_pkg LS_*)
//   result  extended DATA_W result
// No alignment checking here; callers reject misaligned commands.
module load_extract
  import load_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = 2
) (
  input  logic [DATA_W-1:0] word,
  input  logic [OFF_W-1:0]  off,
  input  logic [2:0]        size,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W-1:0] lane;

  // Bring the addressed byte down to bit 0.
  assign lane = word >> {off, 3'b000};

  // NOTE: every output of a combinational block gets a value on every path
  // (here via the default arm) so no latch is inferred.
  // A size cast of a $signed operand sign-extends; of an unsigned one, zero-extends.
  always_comb begin
    case (size)
      LS_LB:   result = DATA_W'($signed(lane[7:0]));
      LS_LBU:  result = DATA_W'(lane[7:0]);
      LS_LH:   result = DATA_W'($signed(lane[15:0]));
      LS_LHU:  result = DATA_W'(lane[15:0]);
      LS_LW:   result = DATA_W'($signed(lane[31:0]));
      LS_LWU:  result = DATA_W'(lane[31:0]);
      default: result = lane;  // ld passes through
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// load_unit: multi-cycle memory load unit.
//   clk, rst_n   clock, asynchronous active-low reset
//   start        command strobe, honoured only when idle
//   addr         byte address of the load
//   load_size    size code (load_pkg LS_*)
//   busy         high whenever not idle
//   done         one-cycle completion pulse
//   data_out     extended result, held until the next successful load
//   misalign     alignment/illegal-code fault, valid with done
//   bus_err      memory timeout fault, valid with done
//   bus          data-memory read port (load_unit_if.master)
module load_unit
  import load_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        load_size,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] data_out,
  output logic              misalign,
  output logic              bus_err,
  load_unit_if.master       bus
);

  localparam int         OFF_W    = off_width(DATA_W);
  // The counter counts completed WAIT cycles; the last one is TIMEOUT-1.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [2:0]        size_q;
  logic [OFF_W-1:0]  off_q;
  logic [7:0]        cnt;
  logic [OFF_W-1:0]  off_in;
  logic              cmd_fault;
  logic              accept, take, expire;
  logic [DATA_W-1:0] lane_ext;

  assign off_in    = addr[OFF_W-1:0];
  assign cmd_fault = is_fault(load_size, 3'(off_in), DATA_W);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    take      = 1'b0;
    expire    = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept    = 1'b1;
        state_nxt = cmd_fault ? DONE : WAIT;
      end
      WAIT: begin
        // Data arriving on the last allowed cycle still counts.
        if (bus.mem_ready) begin
          take      = 1'b1;
          state_nxt = DONE;
        end else if (cnt == CNT_LAST) begin
          expire    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size_q         <= '0;
      off_q          <= '0;
      cnt            <= '0;
      data_out       <= '0;
      misalign       <= 1'b0;
      bus_err        <= 1'b0;
      bus.mem_rd_req <= 1'b0;
      bus.mem_addr   <= '0;
    end else begin
      if (accept) begin
        size_q   <= load_size;
        off_q    <= off_in;
        cnt      <= '0;
        misalign <= cmd_fault;
        bus_err  <= 1'b0;
        if (!cmd_fault) begin
          bus.mem_rd_req <= 1'b1;
          bus.mem_addr   <= {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        end
      end
      if (state == WAIT) cnt <= cnt + 8'd1;
      if (take) begin
        data_out       <= lane_ext;
        bus.mem_rd_req <= 1'b0;
      end
      if (expire) begin
        bus.mem_rd_req <= 1'b0;
        bus_err        <= 1'b1;
      end
    end
  end

  load_extract #(
    .DATA_W(DATA_W),
    .OFF_W (OFF_W)
  ) u_extract (
    .word  (bus.mem_rdata),
    .off   (off_q),
    .size  (size_q),
    .result(lane_ext)
  );

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_load_unit.sv
// tb_load_unit: self-checking bench for load_unit.
// Two instances: 32-bit datapath with TIMEOUT=3 and 64-bit with TIMEOUT=5.
// Expected results come from a byte-count/sign arithmetic model.
module tb_load_unit;
  import load_pkg::*;

  localparam int TO32 = 3;
  localparam int TO64 = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        st32, st64;
  logic [31:0] a32, a64;
  logic [2:0]  sz32, sz64;
  logic        busy32, done32, mis32, be32;
  logic        busy64, done64, mis64, be64;
  logic [31:0] d32;
  logic [63:0] d64;

  load_unit_if #(.DATA_W(32), .ADDR_W(32)) m32 ();
  load_unit_if #(.DATA_W(64), .ADDR_W(32)) m64 ();

  load_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TO32)) u32 (
    .clk(clk), .rst_n(rst_n), .start(st32), .addr(a32), .load_size(sz32),
    .busy(busy32), .done(done32), .data_out(d32), .misalign(mis32),
    .bus_err(be32), .bus(m32)
  );

  load_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(TO64)) u64 (
    .clk(clk), .rst_n(rst_n), .start(st64), .addr(a64), .load_size(sz64),
    .busy(busy64), .done(done64), .data_out(d64), .misalign(mis64),
    .bus_err(be64), .bus(m64)
  );

  int checks = 0;
  int failures = 0;
  logic [63:0] prev32 = '0;
  logic [63:0] prev64 = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_cmd(input bit w, input logic s, input logic [31:0] a, input logic [2:0] z);
    if (w) begin st64 = s; a64 = a; sz64 = z; end
    else   begin st32 = s; a32 = a; sz32 = z; end
  endtask

  task automatic drive_mem(input bit w, input logic rdy, input logic [63:0] rd);
    if (w) begin m64.mem_ready = rdy; m64.mem_rdata = rd; end
    else   begin m32.mem_ready = rdy; m32.mem_rdata = rd[31:0]; end
  endtask

  task automatic sample(input bit w, output logic bsy, output logic dn, output logic req,
                        output logic mis, output logic be, output logic [63:0] dout,
                        output logic [31:0] ma);
    if (w) begin
      bsy = busy64; dn = done64; req = m64.mem_rd_req; mis = mis64; be = be64;
      dout = d64; ma = m64.mem_addr;
    end else begin
      bsy = busy32; dn = done32; req = m32.mem_rd_req; mis = mis32; be = be32;
      dout = {32'h0, d32}; ma = m32.mem_addr;
    end
  endtask

  // Reference: byte count and signedness per code, then shift/mask/extend.
  task automatic model(input bit w, input logic [31:0] a, input logic [2:0] z,
                       input logic [63:0] rd, output bit flt, output logic [63:0] val);
    int nb, wb, off;
    bit sgn;
    logic [63:0] mask;
    wb = w ? 8 : 4;
    off = int'(a % wb);
    case (z)
      3'd0: begin nb = 4; sgn = 1; end
      3'd1: begin nb = 1; sgn = 1; end
      3'd2: begin nb = 2; sgn = 1; end
      3'd3: begin nb = 1; sgn = 0; end
      3'd4: begin nb = 2; sgn = 0; end
      3'd5: begin nb = 4; sgn = 0; end
      3'd6: begin nb = 8; sgn = 0; end
      default: begin nb = 0; sgn = 0; end
    endcase
    val = '0;
    if (nb == 0) flt = 1;
    else flt = (!w && nb == 8) || (!w && z == 3'd5) || (off % nb != 0);
    if (!flt) begin
      mask = (nb == 8) ? '1 : ((64'd1 << (8 * nb)) - 64'd1);
      val = (rd >> (off * 8)) & mask;
      if (sgn && val[8 * nb - 1]) val = val | ~mask;
      if (!w) val = val & 64'hFFFF_FFFF;
    end
  endtask

  // One complete load. delay = WAIT cycle index on which mem_ready rises
  // (>= timeout means never). poke = re-pulse start while busy.
  task automatic do_load(input bit w, input logic [31:0] a, input logic [2:0] z,
                         input logic [63:0] rd, input int delay, input bit poke);
    bit flt, tout;
    logic [63:0] ev, prev, exp_d, dout;
    logic bsy, dn, req, mis, be;
    logic [31:0] ma;
    int to, got, ek;
    to = w ? TO64 : TO32;
    prev = w ? prev64 : prev32;
    model(w, a, z, rd, flt, ev);
    @(negedge clk);
    drive_cmd(w, 1'b1, a, z);
    drive_mem(w, 1'b0, {$urandom, $urandom});
    @(posedge clk); #1;
    drive_cmd(w, 1'b0, a ^ 32'h5, z);
    sample(w, bsy, dn, req, mis, be, dout, ma);
    if (flt) begin
      check("flt_done", dn, 1);
      check("flt_misalign", mis, 1);
      check("flt_req", req, 0);
      check("flt_buserr", be, 0);
      check("flt_data", dout, prev);
    end else begin
      check("mem_addr", ma, a & ~(w ? 32'h7 : 32'h3));
      got = -1;
      for (int i = 0; i < 64; i++) begin
        sample(w, bsy, dn, req, mis, be, dout, ma);
        check("wait_req", req, 1);
        check("wait_done", dn, 0);
        drive_mem(w, i == delay, (i == delay) ? rd : {$urandom, $urandom});
        if (poke && i == 0) drive_cmd(w, 1'b1, a + 32'd1, LS_LBU);
        @(posedge clk); #1;
        drive_mem(w, 1'b0, {$urandom, $urandom});
        if (poke) drive_cmd(w, 1'b0, a, z);
        sample(w, bsy, dn, req, mis, be, dout, ma);
        if (dn) begin got = i; break; end
      end
      tout = (delay >= to);
      ek = tout ? to - 1 : delay;
      exp_d = tout ? prev : ev;
      check("latency", 64'(got), 64'(ek));
      check("done_buserr", be, 64'(tout));
      check("done_misalign", mis, 0);
      check("done_req", req, 0);
      check("done_data", dout, exp_d);
      if (w) prev64 = exp_d; else prev32 = exp_d;
    end
    @(posedge clk); #1;
    sample(w, bsy, dn, req, mis, be, dout, ma);
    check("after_done", dn, 0);
    check("after_busy", bsy, 0);
    check("after_data", dout, w ? prev64 : prev32);
    if (poke) begin
      @(posedge clk); #1;
      sample(w, bsy, dn, req, mis, be, dout, ma);
      check("poke_no_second_done", dn, 0);
      check("poke_idle", bsy, 0);
    end
  endtask

  initial begin
    logic bsy, dn, req, mis, be;
    logic [63:0] dout;
    logic [31:0] ma;
    drive_cmd(0, 1'b0, '0, '0);
    drive_cmd(1, 1'b0, '0, '0);
    drive_mem(0, 1'b0, '0);
    drive_mem(1, 1'b0, '0);
    #2;
    for (int w = 0; w < 2; w++) begin
      sample(w[0], bsy, dn, req, mis, be, dout, ma);
      check("rst_busy", bsy, 0);
      check("rst_done", dn, 0);
      check("rst_req", req, 0);
      check("rst_addr", ma, 0);
      check("rst_data", dout, 0);
      check("rst_flags", {mis, be}, 0);
    end
    @(negedge clk); rst_n = 1'b1;

    // Directed 32-bit cases
    do_load(0, 32'h1001, LS_LB,  64'h8081_F2F3, 0, 0);
    do_load(0, 32'h1001, LS_LBU, 64'h8081_F2F3, 0, 0);
    do_load(0, 32'h2002, LS_LH,  64'h8001_1234, 1, 0);
    do_load(0, 32'h2002, LS_LHU, 64'h8001_1234, 2, 0);
    do_load(0, 32'h2003, LS_LH,  64'h8001_1234, 0, 0);
    do_load(0, 32'h2000, LS_LW,  64'hDEAD_BEEF, 0, 0);
    do_load(0, 32'h2000, LS_LD,  64'hDEAD_BEEF, 0, 0);
    // Directed 64-bit cases
    do_load(1, 32'h0104, LS_LW,  64'h8000_0000_7FFF_FFFF, 0, 0);
    do_load(1, 32'h0104, LS_LWU, 64'h8000_0000_7FFF_FFFF, 0, 0);
    do_load(1, 32'h0100, LS_LD,  64'h8000_0000_7FFF_FFFF, 0, 0);
    do_load(1, 32'h0104, LS_LD,  64'h8000_0000_7FFF_FFFF, 0, 0);
    do_load(1, 32'h0107, LS_LB,  64'h8000_0000_7FFF_FFFF, 3, 0);
    // Timeout, ready on the last allowed cycle, and recovery
    do_load(0, 32'h4000, LS_LB, 64'h55, 99, 0);
    do_load(0, 32'h4000, LS_LB, 64'h7A, 0, 0);
    do_load(0, 32'h4002, LS_LH, 64'h9ABC_0000, TO32 - 1, 0);
    do_load(1, 32'h4000, LS_LD, 64'h1, 99, 0);
    // start while busy is ignored
    do_load(0, 32'h5000, LS_LB, 64'hC3, 1, 1);

    // Reset in the middle of WAIT
    @(negedge clk);
    drive_cmd(0, 1'b1, 32'h3000, LS_LW);
    @(posedge clk); #1;
    drive_cmd(0, 1'b0, 32'h3000, LS_LW);
    sample(0, bsy, dn, req, mis, be, dout, ma);
    check("pre_rst_req", req, 1);
    #2 rst_n = 1'b0;
    #1;
    sample(0, bsy, dn, req, mis, be, dout, ma);
    check("mid_rst_req", req, 0);
    check("mid_rst_busy", bsy, 0);
    check("mid_rst_data", dout, 0);
    prev32 = '0;
    prev64 = '0;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    drive_mem(0, 1'b1, 64'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      sample(0, bsy, dn, req, mis, be, dout, ma);
      check("post_rst_no_done", dn, 0);
    end
    drive_mem(0, 1'b0, '0);
    do_load(0, 32'h3000, LS_LW, 64'h1234_5678, 0, 0);

    // Randomized loads against the model
    for (int n = 0; n < 40; n++) begin
      bit w;
      w = $urandom_range(0, 1) != 0;
      do_load(w, $urandom, 3'($urandom_range(0, 7)), {$urandom, $urandom},
              $urandom_range(0, (w ? TO64 : TO32) + 1), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
